// File: rtl/sobel_window_gen_pkg.sv
// Shared constants, window tap layout and FSM encoding for the 3x3 Sobel window generator.
package sobel_window_gen_pkg;

  localparam int unsigned IMG_W = 28;
  localparam int unsigned IMG_H = 28;
  localparam int unsigned PIX_W = 5;
  localparam int unsigned OUT_W = IMG_W - 2;
  localparam int unsigned OUT_H = IMG_H - 2;
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned WIN_W = 9 * PIX_W;

  // Tap indices in kernel order; P00 is the top-left pixel and sits in the MSBs of win_data.
  localparam int unsigned P00 = 0;
  localparam int unsigned P01 = 1;
  localparam int unsigned P02 = 2;
  localparam int unsigned P10 = 3;
  localparam int unsigned P11 = 4;
  localparam int unsigned P12 = 5;
  localparam int unsigned P20 = 6;
  localparam int unsigned P21 = 7;
  localparam int unsigned P22 = 8;

  function automatic int unsigned tap_lsb(input int unsigned tap);
    return (8 - tap) * PIX_W;
  endfunction

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StStream,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out stream bundle between the SPI RAM source, the window generator and
// the Sobel filter.
interface sobel_window_gen_if;
  import sobel_window_gen_pkg::*;

  logic             frame_start;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_ready;
  logic             win_valid;
  logic             win_ready;
  logic [WIN_W-1:0] win_data;
  logic [4:0]       win_x;
  logic [4:0]       win_y;
  logic             frame_done;

  modport master (
    output frame_start, pix_valid, pix_data, win_ready,
    input  pix_ready, win_valid, win_data, win_x, win_y, frame_done
  );

  modport slave (
    input  frame_start, pix_valid, pix_data, win_ready,
    output pix_ready, win_valid, win_data, win_x, win_y, frame_done
  );

endinterface

// File: rtl/sobel_line_buffer.sv
// One image row of pixels: synchronous write, asynchronous read at the same column address.
module sobel_line_buffer #(
  parameter int unsigned Depth = 28,
  parameter int unsigned Width = 5
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(Depth)-1:0] i_addr,
  input  logic [Width-1:0]         i_wdata,
  output logic [Width-1:0]         o_rdata
);

  logic [Width-1:0] r_mem [Depth];

  // Read returns the previous row's pixel before this cycle's write lands.
  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-stream to 3x3 window converter: two line buffers feed a 3-row shift array, and one
// window is registered per accepted pixel at row>=2, col>=2.
module sobel_window_gen
  import sobel_window_gen_pkg::*;
(
  input logic               clk,
  input logic               reset,
  sobel_window_gen_if.slave bus
);

  localparam logic [COL_W-1:0] ColLast = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] RowLast = ROW_W'(IMG_H - 1);

  state_e                     r_state;
  state_e                     w_state_d;
  logic [COL_W-1:0]           r_col;
  logic [ROW_W-1:0]           r_row;
  // Last two columns of each of the three window rows; row 0 is the top row.
  logic [2:0][1:0][PIX_W-1:0] r_arr;
  logic                       r_win_valid;
  logic [WIN_W-1:0]           r_win_data;
  logic [4:0]                 r_win_x;
  logic [4:0]                 r_win_y;
  logic                       r_frame_done;
  logic                       w_done;
  logic                       w_pix_ready;
  logic                       w_accept;
  logic                       w_emit;
  logic                       w_row_end;
  logic [PIX_W-1:0]           w_lb0_rd;
  logic [PIX_W-1:0]           w_lb1_rd;

  assign w_pix_ready = ((r_state == StFill) || (r_state == StStream)) && !bus.frame_start &&
                       (!r_win_valid || bus.win_ready);
  assign w_accept    = bus.pix_valid && w_pix_ready;
  assign w_row_end   = (r_col == ColLast);
  assign w_emit      = w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

  sobel_line_buffer #(
    .Depth (IMG_W),
    .Width (PIX_W)
  ) u_lb0 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (r_col),
    .i_wdata (bus.pix_data),
    .o_rdata (w_lb0_rd)
  );

  sobel_line_buffer #(
    .Depth (IMG_W),
    .Width (PIX_W)
  ) u_lb1 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (r_col),
    .i_wdata (w_lb0_rd),
    .o_rdata (w_lb1_rd)
  );

  always_comb begin
    w_state_d = r_state;
    w_done    = 1'b0;
    if (bus.frame_start) begin
      w_state_d = StFill;
    end else begin
      case (r_state)
        StFill: begin
          if (w_accept && w_row_end && (r_row == ROW_W'(1))) w_state_d = StStream;
        end
        StStream: begin
          if (w_accept && w_row_end && (r_row == RowLast)) w_state_d = StDrain;
        end
        StDrain: begin
          if (r_win_valid && bus.win_ready) begin
            w_state_d = StDone;
            w_done    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_frame_done <= w_done;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col       <= '0;
      r_row       <= '0;
      r_arr       <= '0;
      r_win_valid <= 1'b0;
      r_win_data  <= '0;
      r_win_x     <= '0;
      r_win_y     <= '0;
    end else if (bus.frame_start) begin
      r_col       <= '0;
      r_row       <= '0;
      r_win_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_arr[0][0] <= r_arr[0][1];
        r_arr[0][1] <= w_lb1_rd;
        r_arr[1][0] <= r_arr[1][1];
        r_arr[1][1] <= w_lb0_rd;
        r_arr[2][0] <= r_arr[2][1];
        r_arr[2][1] <= bus.pix_data;
        if (w_row_end) begin
          r_col <= '0;
          r_row <= (r_row == RowLast) ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
      if (w_emit) begin
        r_win_valid <= 1'b1;
        r_win_data  <= {r_arr[0][0], r_arr[0][1], w_lb1_rd,
                        r_arr[1][0], r_arr[1][1], w_lb0_rd,
                        r_arr[2][0], r_arr[2][1], bus.pix_data};
        r_win_x     <= 5'(r_col) - 5'd2;
        r_win_y     <= 5'(r_row) - 5'd2;
      end else if (bus.win_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  assign bus.pix_ready  = w_pix_ready;
  assign bus.win_valid  = r_win_valid;
  assign bus.win_data   = r_win_data;
  assign bus.win_x      = r_win_x;
  assign bus.win_y      = r_win_y;
  assign bus.frame_done = r_frame_done;

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
Streaming 3x3 window generator that sits directly upstream of sobel_filter. It accepts a raster-order pixel stream of one IMG_W x IMG_H frame from the SPI RAM source. Two internal line buffers plus a 3x3 register array produce every valid 3x3 neighbourhood, one per handshake. Output packing and coordinates match the filter's kernel ordering and its (IMG_W-2) x (IMG_H-2) result grid.

Parameters:
IMG_W, 28, frame width in pixels (>=3)
IMG_H, 28, frame height in pixels (>=3)
PIX_W, 5, bits per unsigned pixel

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
frame_start  in  1  single-cycle pulse; starts a new frame and aborts any frame in progress
pix_valid  in  1  pix_data valid
pix_data  in  PIX_W  pixel, raster order (row 0 col 0 first)
pix_ready  out  1  block can accept a pixel this cycle
win_valid  out  1  win_data/win_x/win_y valid (registered)
win_ready  in  1  downstream accepts the window
win_data  out  9*PIX_W  {p00,p01,p02,p10,p11,p12,p20,p21,p22}, MSB first; p00 = top-left; same order as the kernel taps
win_x  out  5  window top-left column, 0..IMG_W-3
win_y  out  5  window top-left row, 0..IMG_H-3
frame_done  out  1  one-cycle pulse after the last window of the frame is accepted

Behaviour:
- Reset (async, immediate): state IDLE; pix_ready=0, win_valid=0, win_data=0, win_x=0, win_y=0, frame_done=0; row/col counters =0. Line buffer contents are don't-care.
- States and transitions:
  - IDLE -> FILL on frame_start.
  - FILL: rows 0-1 are accepted; no windows are produced.
  - FILL -> STREAM after pixel (1, IMG_W-1) is accepted.
  - STREAM -> DRAIN after pixel (IMG_H-1, IMG_W-1) is accepted.
  - DRAIN -> DONE when the final window is accepted; frame_done pulses in that transition cycle.
  - DONE -> FILL on frame_start.
- frame_start in any state:
  - Next state FILL; counters cleared; win_valid cleared next cycle; any pending window is dropped.
  - frame_done is not asserted for the aborted frame.
- pix_ready:
  - Combinational: (state in FILL or STREAM) and !frame_start and (!win_valid or win_ready).
  - A pixel presented in the same cycle as frame_start is discarded.
- Pixel accept = pix_valid and pix_ready. On accept:
  - Write into the line buffers at column col.
  - Shift the 3x3 array left by one, loading column {lb1[col], lb0[col], pix_data}.
  - Advance col; at IMG_W-1, wrap col to 0 and increment row.
- Window emission:
  - Emitted only on acceptance of pixel (r,c) with r>=2 and c>=2.
  - The next cycle has win_valid=1, win_x=c-2, win_y=r-2, win_data = pixels rows r-2..r, cols c-2..c.
  - Latency: 1 cycle from the pixel handshake.
  - Pixels with c<2 only prime the array, so no window spans a row wrap.
- Output hold: win_valid, win_data, win_x and win_y are held stable while win_valid and !win_ready. Back-pressure stalls input through pix_ready. No window is lost or duplicated.
- Accepting a window without a new one loading clears win_valid. Accept and load in the same cycle keep win_valid=1 with the new data.
- Windows per frame: (IMG_W-2)*(IMG_H-2), which is 676 at the defaults.
- Extra pixels after the frame end are not accepted: pix_ready=0 in DRAIN, DONE and IDLE.
- Arithmetic: counters are unsigned $clog2(IMG_W) and $clog2(IMG_H) bits. No arithmetic is performed on pixel values.

Decomposition:
- Shared package holds:
  - IMG_W, IMG_H, PIX_W, and the derived OUT_W=IMG_W-2 and OUT_H=IMG_H-2.
  - Window tap index constants P00..P22 with bit-slice offsets, used by sobel_filter for the kernel pairing.
  - The state encoding (IDLE, FILL, STREAM, DRAIN, DONE).
- One sub-module: sobel_line_buffer.
  - IMG_W-deep x PIX_W register array with synchronous write and asynchronous read at the same column address.
  - Instantiated twice (lb0 = previous row, lb1 = row before that); lb0's read data feeds lb1's write data.

Test Plan:
1. Ramp frame, pixel(r,c)=(r*28+c) mod 32, pix_valid and win_ready held 1 → first win_valid exactly 1 cycle after the 59th accept, with win_x=0, win_y=0, win_data={0,1,2,28,29,30,24,25,26}. Exactly 676 windows follow, then one frame_done pulse.
2. Row wrap on the same frame → window (x=25,y=0) is followed directly by (x=0,y=1). No window is emitted on accepts with c=0 or c=1.
3. win_ready pseudo-random at 50% duty, pix_valid random → window sequence identical to scenario 1 and no duplicates. Outputs stay stable during every stall, and pix_ready=0 whenever win_valid and !win_ready.
4. frame_start pulsed after 400 accepted pixels, then a new all-7 frame → win_valid=0 on the next cycle. No stale windows appear, and every new window's win_data is nine copies of 7. A single frame_done pulse follows.
5. Asynchronous reset asserted mid-STREAM between clock edges → all outputs 0 immediately. After release, pix_ready stays 0 until frame_start.
6. Pixels offered after the frame completes (DONE) → pix_ready=0, no handshake occurs, and outputs are unchanged.
